// File: rtl/ext_obi_mailbox_if.sv
// OBI bus bundle between an initiator (CPU/DMA crossbar) and the mailbox responder.
// Signals: req/gnt address handshake, addr/we/be/wdata request payload,
//    rvalid/rdata response one cycle after each grant.
interface ext_obi_mailbox_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ext_obi_mailbox.sv
// OBI-written word FIFO mailbox drained by a valid/ready stream, with status/ctrl/threshold regs.
// Latency: grant same cycle, response next cycle; a pushed word is visible on the stream one cycle later.
// Backpressure: the bus never stalls (push when full is dropped and flagged); the stream holds while ready_i is low.
// Ports: clk_i/rst_ni (sync, active-low), bus (OBI slave modport), data_o/valid_o/ready_i stream,
//    irq_o level interrupt when count >= nonzero threshold.
module ext_obi_mailbox #(
   parameter  int unsigned Depth = 8,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   ext_obi_mailbox_if.slave      bus,
   output logic [31:0]           data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  irq_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_THRESH = 2'd3
   } reg_e;

   logic [31:0]     mem_q [Depth];
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d, thresh_q, thresh_d;
   logic            ovf_q, ovf_d;
   logic            rvalid_q, irq_q;
   logic [31:0]     rdata_q;

   reg_e            sel;
   logic            wr, rd, empty, full, pop, push_req, push_ok, flush;
   logic [31:0]     head, status, rd_val;
   logic            unused_bits;

   // No wait states: every request is taken in the cycle it is presented.
   assign bus.gnt = bus.req;
   assign sel     = reg_e'(bus.addr[3:2]);
   assign wr      = bus.req & bus.we;
   assign rd      = bus.req & ~bus.we;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(Depth));
   assign head    = empty ? 32'h0 : mem_q[rptr_q];
   assign pop     = ~empty & ready_i;

   // A pop in the same cycle frees the head slot, so a push into a full FIFO still succeeds.
   assign push_req = wr & (sel == REG_DATA);
   assign push_ok  = push_req & (~full | pop);
   assign flush    = wr & (sel == REG_CTRL) & bus.wdata[0];

   // Byte enables and non-decoded address bits carry no meaning here.
   assign unused_bits = ^{bus.be, bus.addr[31:4], bus.addr[1:0]};

   always_comb begin
      status              = 32'h0;
      status[0]           = empty;
      status[1]           = full;
      status[2]           = ovf_q;
      status[8 +: CntW]   = count_q;
   end

   always_comb begin
      rd_val = 32'h0;
      case (sel)
         REG_DATA:   rd_val = head;
         REG_STATUS: rd_val = status;
         REG_CTRL:   rd_val = 32'h0;
         REG_THRESH: rd_val = 32'(thresh_q);
         default:    rd_val = 32'h0;
      endcase
   end

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      thresh_d = thresh_q;
      if (flush) begin
         // Flush overrides any concurrent stream pop.
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         if (pop)                 rptr_d = rptr_q + PtrW'(1);
         if (push_ok)             wptr_d = wptr_q + PtrW'(1);
         if (push_req & ~push_ok) ovf_d  = 1'b1;
         if (push_ok & ~pop)
            count_d = count_q + CntW'(1);
         else if (pop & ~push_ok)
            count_d = count_q - CntW'(1);
      end
      if (wr && (sel == REG_THRESH)) thresh_d = bus.wdata[CntW-1:0];
   end

   // Storage is not reset: contents are meaningless whenever count is 0.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push_ok) mem_q[wptr_q] <= bus.wdata;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         thresh_q <= '0;
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0;
         irq_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         thresh_q <= thresh_d;
         ovf_q    <= ovf_d;
         rvalid_q <= bus.req;
         // Read data captures pre-update state of the grant cycle.
         rdata_q  <= rd ? rd_val : 32'h0;
         irq_q    <= (thresh_q != '0) && (count_q >= thresh_q);
      end
   end

   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;
   assign data_o     = head;
   assign valid_o    = ~empty;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_ext_obi_mailbox.sv
// Self-checking bench for ext_obi_mailbox: queue-based reference model plus literal checks.
// Ports exercised: OBI bus via interface, stream data/valid/ready, irq.
module tb_ext_obi_mailbox;
   localparam int DEPTH = 8;

   logic        clk;
   logic        rst_n;
   logic        ready;
   logic [31:0] data;
   logic        valid;
   logic        irq;

   ext_obi_mailbox_if bus();

   ext_obi_mailbox #(.Depth(DEPTH)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .bus     (bus),
      .data_o  (data),
      .valid_o (valid),
      .ready_i (ready),
      .irq_o   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model state
   logic [31:0] q[$];
   bit          m_ovf;
   int          m_thr;
   bit          e_rvalid;
   logic [31:0] e_rdata;
   bit          e_irq;

   function automatic logic [31:0] model_read(input logic [1:0] a);
      int sz;
      sz = q.size();
      case (a)
         2'd0:    return (sz != 0) ? q[0] : 32'h0;
         2'd1:    return 32'((sz << 8) + (m_ovf ? 4 : 0) + ((sz == DEPTH) ? 2 : 0) + ((sz == 0) ? 1 : 0));
         2'd3:    return 32'(m_thr);
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      int   sz;
      bit   do_pop;
      bit   do_flush;
      bit   irq_n;
      sz = q.size();
      if (!rst_n) begin
         q.delete();
         m_ovf    = 1'b0;
         m_thr    = 0;
         e_rvalid = 1'b0;
         e_rdata  = 32'h0;
         e_irq    = 1'b0;
      end else begin
         irq_n    = (m_thr != 0) && (sz >= m_thr);
         e_rvalid = bus.req;
         e_rdata  = (bus.req && !bus.we) ? model_read(bus.addr[3:2]) : 32'h0;
         do_pop   = (sz != 0) && ready;
         do_flush = bus.req && bus.we && (bus.addr[3:2] == 2'd2) && bus.wdata[0];
         if (do_flush) begin
            q.delete();
            m_ovf = 1'b0;
         end else begin
            if (do_pop) void'(q.pop_front());
            if (bus.req && bus.we && (bus.addr[3:2] == 2'd0)) begin
               if (sz < DEPTH || do_pop) q.push_back(bus.wdata);
               else m_ovf = 1'b1;
            end
         end
         if (bus.req && bus.we && (bus.addr[3:2] == 2'd3)) m_thr = int'(bus.wdata[3:0]);
         e_irq = irq_n;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp gnt", 32'(bus.gnt), 32'(bus.req));
         chk("cmp rvalid", 32'(bus.rvalid), 32'(e_rvalid));
         if (e_rvalid) chk("cmp rdata", bus.rdata, e_rdata);
         chk("cmp valid", 32'(valid), (q.size() != 0) ? 32'h1 : 32'h0);
         chk("cmp data", data, (q.size() != 0) ? q[0] : 32'h0);
         chk("cmp irq", 32'(irq), 32'(e_irq));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic acc(input logic w, input logic [1:0] a, input logic [31:0] d);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = {28'h0, a, 2'b00};
      bus.wdata = d;
      bus.be    = 4'hF;
      step();
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.wdata = 32'h0;
   endtask

   task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      acc(1'b0, a, 32'h0);
      chk({name, " rvalid"}, 32'(bus.rvalid), 32'h1);
      chk(name, bus.rdata, exp);
   endtask

   logic [31:0] drain [8];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      ready     = 1'b0;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = 32'h0;
      bus.be    = 4'h0;
      bus.wdata = 32'h0;
      repeat (3) step();
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Reset state and empty status
      chk("rst rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst valid", 32'(valid), 32'h0);
      chk("rst data", data, 32'h0);
      chk("rst irq", 32'(irq), 32'h0);
      read_chk("status empty", 2'd1, 32'h0000_0001);
      acc(1'b1, 2'd1, 32'hFFFF_FFFF);
      read_chk("status ro", 2'd1, 32'h0000_0001);
      read_chk("ctrl reads 0", 2'd2, 32'h0);

      // Fill with back-to-back writes, consumer stalled
      for (int i = 0; i < 8; i++) begin
         acc(1'b1, 2'd0, 32'hA0 + 32'(i));
         chk("wr rvalid", 32'(bus.rvalid), 32'h1);
      end
      read_chk("status full", 2'd1, 32'h0000_0802);
      read_chk("data peek", 2'd0, 32'h0000_00A0);
      chk("head after peek", data, 32'h0000_00A0);

      // Overflow and flush
      acc(1'b1, 2'd0, 32'hBB);
      read_chk("status ovf", 2'd1, 32'h0000_0806);
      acc(1'b1, 2'd2, 32'h1);
      read_chk("status flushed", 2'd1, 32'h0000_0001);
      chk("valid flushed", 32'(valid), 32'h0);

      // Threshold interrupt
      acc(1'b1, 2'd3, 32'h3);
      read_chk("thresh rb", 2'd3, 32'h3);
      acc(1'b1, 2'd0, 32'h11);
      acc(1'b1, 2'd0, 32'h22);
      acc(1'b1, 2'd0, 32'h33);
      chk("irq lag", 32'(irq), 32'h0);
      step();
      chk("irq rise", 32'(irq), 32'h1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("irq hold", 32'(irq), 32'h1);
      step();
      chk("irq fall", 32'(irq), 32'h0);

      // Fill to full, then push with simultaneous pop
      for (int i = 0; i < 6; i++) acc(1'b1, 2'd0, 32'h40 + 32'(i));
      read_chk("status full2", 2'd1, 32'h0000_0802);
      ready = 1'b1;
      acc(1'b1, 2'd0, 32'hCC);
      ready = 1'b0;
      read_chk("status push+pop", 2'd1, 32'h0000_0802);
      drain = '{32'h33, 32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'hCC};
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain", data, drain[i]);
         step();
      end
      ready = 1'b0;
      chk("drained valid", 32'(valid), 32'h0);

      // Reset in the cycle after a granted read
      for (int i = 0; i < 4; i++) acc(1'b1, 2'd0, 32'h50 + 32'(i));
      step();
      chk("pre-rst irq", 32'(irq), 32'h1);
      acc(1'b0, 2'd1, 32'h0);
      chk("pre-rst rvalid", 32'(bus.rvalid), 32'h1);
      rst_n = 1'b0;
      step();
      chk("mid-rst rvalid", 32'(bus.rvalid), 32'h0);
      chk("mid-rst rdata", bus.rdata, 32'h0);
      chk("mid-rst valid", 32'(valid), 32'h0);
      chk("mid-rst data", data, 32'h0);
      chk("mid-rst irq", 32'(irq), 32'h0);
      rst_n = 1'b1;
      read_chk("post-rst status", 2'd1, 32'h0000_0001);
      read_chk("post-rst thresh", 2'd3, 32'h0);
      step();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
